// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned FUNC3_W = 3;
    localparam int unsigned WBSEL_W = 2;
    localparam int unsigned CAUSE_W = 2;

    // Supported major opcodes
    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // Write-back mux encodings
    localparam logic [WBSEL_W-1:0] WB_DM  = 2'b00;
    localparam logic [WBSEL_W-1:0] WB_ALU = 2'b01;
    localparam logic [WBSEL_W-1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE        = 2'b00,
        CAUSE_ILLEGAL     = 2'b01,
        CAUSE_BUS_TIMEOUT = 2'b10
    } trap_cause_e;

    // Instruction fields kept after FETCH
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [FUNC3_W-1:0] func3;
        logic               bit30;
    } ir_fields_t;

    // ALU-side controls shared by EXEC, MEM and WB
    typedef struct packed {
        logic               op1_sel;
        logic               op2_sel;
        logic [FUNC3_W-1:0] func3;
        logic               subsra;
    } alu_ctrl_t;

    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
        return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // ALU operand/operation selection for a latched instruction
    function automatic alu_ctrl_t alu_ctrl_for(input ir_fields_t ir);
        alu_ctrl_t c;
        c.op1_sel = 1'b1;
        c.op2_sel = 1'b1;
        c.func3   = '0;
        c.subsra  = 1'b0;
        case (ir.opcode)
            OPC_R: begin
                c.op2_sel = 1'b0;
                c.func3   = ir.func3;
                c.subsra  = ir.bit30;
            end
            OPC_I: begin
                c.func3  = ir.func3;
                // bit 30 is immediate data except for the shift-right pair
                c.subsra = (ir.func3 == 3'b101) ? ir.bit30 : 1'b0;
            end
            OPC_BRANCH: c.op1_sel = 1'b0;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles and flags a bus timeout.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Wait counter: advances on each unanswered cycle, parks at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !ready && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A ready in the limit cycle still completes the access
    assign timeout = (MEM_TIMEOUT != 0) && enable && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I multi-cycle datapath.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W   = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 branch_taken,
    input  logic                 dm_ready,
    input  logic                 halt_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 rf_we,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic                 op1_sel,
    output logic                 op2_sel,
    output logic [WBSEL_W-1:0]   wb_sel,
    output logic [FUNC3_W-1:0]   alu_func3,
    output logic                 alu_subsra,
    output logic [FUNC3_W-1:0]   br_func3,
    output logic                 trap,
    output logic [CAUSE_W-1:0]   trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_e           state_q, state_d;
    trap_cause_e           cause_q, cause_d;
    ir_fields_t            ir_q;
    alu_ctrl_t             alu;
    logic [INSTRET_W-1:0]  instret_q;
    logic                  ir_load;
    logic                  retire;
    logic                  mem_exit;
    logic                  mem_timeout;
    logic                  is_load, is_store, is_branch;
    logic                  unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_load   = (ir_q.opcode == OPC_LOAD);
    assign is_store  = (ir_q.opcode == OPC_STORE);
    assign is_branch = (ir_q.opcode == OPC_BRANCH);
    assign alu       = alu_ctrl_for(ir_q);
    assign ir_load   = (state_q == ST_FETCH) && !halt_req;
    assign mem_exit  = (state_q == ST_MEM) && (dm_ready || mem_timeout);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  (mem_exit),
        .enable (state_q == ST_MEM),
        .ready  (dm_ready),
        .timeout(mem_timeout)
    );

    // State and trap-cause registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Instruction fields captured at fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= '{opcode: instr[6:0], func3: instr[14:12], bit30: instr[30]};
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Next-state, trap cause and retire decision
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!halt_req) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_legal_opcode(ir_q.opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dm_ready) begin
                    if (is_store) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (mem_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS_TIMEOUT;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath controls decoded from state and latched fields
    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        rf_we      = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        op1_sel    = 1'b0;
        op2_sel    = 1'b0;
        wb_sel     = WB_DM;
        alu_func3  = '0;
        alu_subsra = 1'b0;
        br_func3   = '0;
        trap       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Reset parks the state in FETCH; keep the IR strobe quiet meanwhile
                ir_we = !halt_req && reset;
            end
            ST_EXEC: begin
                {op1_sel, op2_sel, alu_func3, alu_subsra} = alu;
                if (is_branch) begin
                    pc_we    = 1'b1;
                    pc_sel   = branch_taken;
                    br_func3 = ir_q.func3;
                end
            end
            ST_MEM: begin
                {op1_sel, op2_sel, alu_func3, alu_subsra} = alu;
                dm_req = 1'b1;
                dm_we  = is_store;
                pc_we  = is_store && dm_ready;
            end
            ST_WB: begin
                {op1_sel, op2_sel, alu_func3, alu_subsra} = alu;
                rf_we  = 1'b1;
                wb_sel = is_load ? WB_DM : WB_ALU;
                pc_we  = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand sequences, random instruction stream.
module tb_multicycle_ctrl;

    localparam int unsigned IW  = 4;
    localparam int unsigned TMO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          branch_taken, dm_ready, halt_req;
    logic          ir_we, pc_we, pc_sel, rf_we, dm_req, dm_we, op1_sel, op2_sel;
    logic [1:0]    wb_sel;
    logic [2:0]    alu_func3;
    logic          alu_subsra;
    logic [2:0]    br_func3;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [IW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.INSTRET_W(IW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr(instr), .branch_taken(branch_taken),
        .dm_ready(dm_ready), .halt_req(halt_req), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .dm_req(dm_req), .dm_we(dm_we),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .wb_sel(wb_sel), .alu_func3(alu_func3),
        .alu_subsra(alu_subsra), .br_func3(br_func3), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    typedef struct packed {
        logic       ir_we, pc_we, pc_sel, rf_we, dm_req, dm_we, op1_sel, op2_sel;
        logic [1:0] wb_sel;
        logic [2:0] alu_func3;
        logic       alu_subsra;
        logic [2:0] br_func3;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic  halt;
        logic  ready;
        logic  taken;
        outs_t o;
    } cyc_t;

    // Directed vector: instruction + memory latency -> latency, cause, EXEC controls
    typedef struct {
        logic [31:0] ins;
        logic        taken;
        int          wait_n;
        int          lat;
        int          cause;
        logic [6:0]  exec_ctl;   // {op1, op2, func3, subsra, pc_sel}
    } vec_t;

    cyc_t        trace[$];
    vec_t        vecs[11];
    logic [31:0] cur_ins;
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned exp_instret = 0;

    function automatic outs_t cur_outs();
        outs_t o;
        o.ir_we = ir_we;     o.pc_we = pc_we;     o.pc_sel = pc_sel;     o.rf_we = rf_we;
        o.dm_req = dm_req;   o.dm_we = dm_we;     o.op1_sel = op1_sel;   o.op2_sel = op2_sel;
        o.wb_sel = wb_sel;   o.alu_func3 = alu_func3; o.alu_subsra = alu_subsra;
        o.br_func3 = br_func3; o.trap = trap;     o.trap_cause = trap_cause;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = cur_outs();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: outputs got %h want %h", name, act, exp);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic check_instret(input string name);
        check_val(name, int'(instret), int'(exp_instret % (2 ** IW)));
    endtask

    // Expected per-cycle behaviour of one instruction, built from its type
    task automatic build_trace(input logic [31:0] ins, input int wait_n, input int halt_n,
                               output bit retires, output bit traps);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       b30;
        bit         is_r, is_i, is_l, is_s, is_b;
        outs_t      z, alu;
        cyc_t       c;
        int         n_mem;
        opc = ins[6:0]; f3 = ins[14:12]; b30 = ins[30];
        is_r = (opc == 7'h33); is_i = (opc == 7'h13); is_l = (opc == 7'h03);
        is_s = (opc == 7'h23); is_b = (opc == 7'h63);
        retires = 1'b0; traps = 1'b0;
        z = '0;
        trace.delete();
        for (int k = 0; k < halt_n; k++) begin
            c.halt = 1'b1; c.ready = 1'($urandom); c.taken = 1'($urandom); c.o = z;
            trace.push_back(c);
        end
        c.halt = 1'b0; c.ready = 1'($urandom); c.taken = 1'($urandom); c.o = z; c.o.ir_we = 1'b1;
        trace.push_back(c);
        c.halt = 1'($urandom); c.ready = 1'($urandom); c.taken = 1'($urandom); c.o = z;
        trace.push_back(c);
        if (!(is_r || is_i || is_l || is_s || is_b)) begin
            for (int k = 0; k < 3; k++) begin
                c.halt = 1'($urandom); c.ready = 1'($urandom); c.o = z;
                c.o.trap = 1'b1; c.o.trap_cause = 2'b01;
                trace.push_back(c);
            end
            traps = 1'b1;
            return;
        end
        alu = z;
        alu.op1_sel    = !is_b;
        alu.op2_sel    = !is_r;
        alu.alu_func3  = (is_r || is_i) ? f3 : 3'b000;
        alu.alu_subsra = is_r ? b30 : ((is_i && f3 == 3'b101) ? b30 : 1'b0);
        c.halt = 1'($urandom); c.ready = 1'($urandom); c.taken = 1'($urandom); c.o = alu;
        if (is_b) begin
            c.o.pc_we = 1'b1; c.o.pc_sel = c.taken; c.o.br_func3 = f3;
            trace.push_back(c);
            retires = 1'b1;
            return;
        end
        trace.push_back(c);
        if (is_l || is_s) begin
            n_mem = (wait_n > int'(TMO)) ? int'(TMO) + 1 : wait_n + 1;
            for (int k = 0; k < n_mem; k++) begin
                c.halt = 1'($urandom); c.taken = 1'($urandom); c.ready = (k == wait_n);
                c.o = alu; c.o.dm_req = 1'b1; c.o.dm_we = is_s; c.o.pc_we = is_s && c.ready;
                trace.push_back(c);
            end
            if (wait_n > int'(TMO)) begin
                for (int k = 0; k < 3; k++) begin
                    c.halt = 1'($urandom); c.ready = 1'($urandom); c.o = z;
                    c.o.trap = 1'b1; c.o.trap_cause = 2'b10;
                    trace.push_back(c);
                end
                traps = 1'b1;
                return;
            end
            if (is_s) begin
                retires = 1'b1;
                return;
            end
        end
        c.halt = 1'($urandom); c.ready = 1'($urandom); c.taken = 1'($urandom);
        c.o = alu; c.o.rf_we = 1'b1; c.o.wb_sel = is_l ? 2'b00 : 2'b01; c.o.pc_we = 1'b1;
        trace.push_back(c);
        retires = 1'b1;
    endtask

    // Drive a built trace cycle by cycle; instr is garbage except in the fetch cycle
    task automatic run_trace(input string tag, input int max_cyc);
        for (int i = 0; i < trace.size() && i < max_cyc; i++) begin
            halt_req     = trace[i].halt;
            dm_ready     = trace[i].ready;
            branch_taken = trace[i].taken;
            instr        = trace[i].o.ir_we ? cur_ins : $urandom;
            #2;
            check_outs($sformatf("%s cyc%0d", tag, i), trace[i].o);
            @(posedge clk); #1;
        end
    endtask

    // Mid-cycle asynchronous reset: everything must drop before any clock edge
    task automatic do_reset(input string tag);
        #2;
        halt_req = 1'b0;
        reset    = 1'b0;
        #1;
        check_outs({tag, " async reset outs"}, '0);
        check_val({tag, " async reset instret"}, int'(instret), 0);
        exp_instret = 0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Run one vector with a memory that answers after wait_n wait cycles
    task automatic run_vec(input vec_t v, input int idx);
        int    cyc, mem_cnt, lat;
        outs_t ex;
        cyc = 0; mem_cnt = 0; lat = -1; ex = '0;
        instr = v.ins; halt_req = 1'b0; branch_taken = v.taken; dm_ready = 1'b0;
        while (lat < 0 && cyc < 60) begin
            #1;
            dm_ready = dm_req && (mem_cnt == v.wait_n);
            #1;
            if (cyc == 2) ex = cur_outs();
            if (cyc > 0 && (ir_we || trap)) begin
                lat = cyc;
            end else begin
                if (dm_req) mem_cnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_val($sformatf("vec%0d latency", idx), lat, v.lat);
        check_val($sformatf("vec%0d trap_cause", idx), int'(trap_cause), v.cause);
        if (v.cause == 0) begin
            check_val($sformatf("vec%0d exec ctl", idx),
                      int'({ex.op1_sel, ex.op2_sel, ex.alu_func3, ex.alu_subsra, ex.pc_sel}),
                      int'(v.exec_ctl));
            exp_instret++;
            check_instret($sformatf("vec%0d instret", idx));
        end else begin
            check_val($sformatf("vec%0d instret at trap", idx), int'(instret),
                      int'(exp_instret % (2 ** IW)));
            do_reset($sformatf("vec%0d", idx));
        end
    endtask

    initial begin
        bit          r, t;
        logic [31:0] ins;
        int          sel, w, h;

        vecs[0]  = '{32'h002081B3, 1'b0, 0,  4,  0, 7'b1_0_000_0_0};  // add
        vecs[1]  = '{32'h0020A283, 1'b0, 3,  8,  0, 7'b1_1_000_0_0};  // lw, 3 waits
        vecs[2]  = '{32'h00208463, 1'b1, 0,  3,  0, 7'b0_1_000_0_1};  // beq taken
        vecs[3]  = '{32'h0020A023, 1'b0, 99, 19, 2, 7'b1_1_000_0_0};  // sw, never ready
        vecs[4]  = '{32'h0000006F, 1'b0, 0,  2,  1, 7'b0_0_000_0_0};  // jal: illegal
        vecs[5]  = '{32'h402081B3, 1'b0, 0,  4,  0, 7'b1_0_000_1_0};  // sub
        vecs[6]  = '{32'h4030D193, 1'b0, 0,  4,  0, 7'b1_1_101_1_0};  // srai
        vecs[7]  = '{32'h40008193, 1'b0, 0,  4,  0, 7'b1_1_000_0_0};  // addi, imm bit 30 set
        vecs[8]  = '{32'h0020A023, 1'b0, 0,  4,  0, 7'b1_1_000_0_0};  // sw, ready at once
        vecs[9]  = '{32'h0020A283, 1'b0, 15, 20, 0, 7'b1_1_000_0_0};  // lw, ready in limit cycle
        vecs[10] = '{32'h00209463, 1'b0, 0,  3,  0, 7'b0_1_000_0_0};  // bne not taken

        reset = 1'b0; instr = '0; branch_taken = 1'b0; dm_ready = 1'b0; halt_req = 1'b0;
        @(posedge clk); #1;
        check_outs("reset outs", '0);
        check_val("reset instret", int'(instret), 0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Halt 5 cycles, then an LW whose memory never answers is cut off by reset
        cur_ins = 32'h0020A283;
        build_trace(cur_ins, 99, 5, r, t);
        run_trace("halt_lw", 11);
        do_reset("mid_mem");

        // Random instruction stream against the reference model
        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            sel = $urandom_range(15, 0);
            if (sel < 3)       ins[6:0] = 7'h33;
            else if (sel < 6)  ins[6:0] = 7'h13;
            else if (sel < 9)  ins[6:0] = 7'h03;
            else if (sel < 12) ins[6:0] = 7'h23;
            else if (sel < 15) ins[6:0] = 7'h63;
            w = ($urandom_range(9, 0) == 0) ? $urandom_range(20, 14) : $urandom_range(4, 0);
            h = ($urandom_range(4, 0) == 0) ? $urandom_range(5, 1) : 0;
            cur_ins = ins;
            build_trace(ins, w, h, r, t);
            run_trace($sformatf("rnd%0d", n), 1000);
            if (t) begin
                do_reset($sformatf("rnd%0d", n));
            end else begin
                if (r) exp_instret++;
                check_instret($sformatf("rnd%0d instret", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
